// File: rtl/avalon_burst_mem_tester.sv
// Avalon-MM burst memory self-test: writes an address-derived pattern over a
// word window in fixed bursts, reads it back and reports errors.
module avalon_burst_mem_tester #(
    parameter int                    ADDR_WIDTH = 29,
    parameter int                    DATA_WIDTH = 64,
    parameter int                    BURST_LEN  = 8,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 29'h0700_0000,
    parameter int                    WORD_COUNT = 1024,
    parameter logic [31:0]           SEED       = 32'hDEAD_BEEF,
    parameter int                    ERR_WIDTH  = 16
) (
    input  logic                    systemClock,
    input  logic                    reset,
    input  logic                    start,
    output logic [ADDR_WIDTH-1:0]   address,
    output logic [7:0]              burstcount,
    output logic [DATA_WIDTH/8-1:0] byteenable,
    output logic                    write,
    output logic [DATA_WIDTH-1:0]   writedata,
    output logic                    read,
    input  logic                    waitrequest,
    input  logic [DATA_WIDTH-1:0]   readdata,
    input  logic                    readdatavalid,
    output logic                    busy,
    output logic                    done,
    output logic                    pass,
    output logic [ERR_WIDTH-1:0]    errorCount,
    output logic [ADDR_WIDTH-1:0]   firstErrorAddress
);

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] WR_BURST = 3'd1;
    localparam logic [2:0] RD_CMD   = 3'd2;
    localparam logic [2:0] RD_DATA  = 3'd3;
    localparam logic [2:0] DONE     = 3'd4;

    localparam logic [ADDR_WIDTH-1:0] STEP      = ADDR_WIDTH'(BURST_LEN);
    localparam logic [ADDR_WIDTH-1:0] END_ADDR  = BASE_ADDR + ADDR_WIDTH'(WORD_COUNT);
    localparam logic [7:0]            LAST_BEAT = 8'(BURST_LEN - 1);
    localparam logic [ERR_WIDTH-1:0]  ERR_MAX   = '1;

    function automatic logic [DATA_WIDTH-1:0] pattern(input logic [ADDR_WIDTH-1:0] a);
        logic [31:0] w;
        w = 32'(a) ^ SEED;
        return {(DATA_WIDTH/32){w}};
    endfunction

    logic [2:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [7:0]            beat_q, beat_d;
    logic [ADDR_WIDTH-1:0] address_q, address_d;
    logic                  write_q, write_d;
    logic [DATA_WIDTH-1:0] writedata_q, writedata_d;
    logic                  read_q, read_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  pass_q, pass_d;
    logic [ERR_WIDTH-1:0]  err_q, err_d;
    logic [ADDR_WIDTH-1:0] first_q, first_d;

    logic [ADDR_WIDTH-1:0] next_wr, next_rd, wr_beat_addr, rd_beat_addr;

    assign next_wr      = wr_ptr_q + STEP;
    assign next_rd      = rd_ptr_q + STEP;
    assign wr_beat_addr = wr_ptr_q + ADDR_WIDTH'(beat_q + 8'd1);
    assign rd_beat_addr = rd_ptr_q + ADDR_WIDTH'(beat_q);

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        beat_d      = beat_q;
        address_d   = address_q;
        write_d     = write_q;
        writedata_d = writedata_q;
        read_d      = read_q;
        busy_d      = busy_q;
        done_d      = done_q;
        pass_d      = pass_q;
        err_d       = err_q;
        first_d     = first_q;
        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d     = WR_BURST;
                    wr_ptr_d    = BASE_ADDR;
                    rd_ptr_d    = BASE_ADDR;
                    beat_d      = 8'd0;
                    address_d   = BASE_ADDR;
                    write_d     = 1'b1;
                    writedata_d = pattern(BASE_ADDR);
                    busy_d      = 1'b1;
                    done_d      = 1'b0;
                    pass_d      = 1'b0;
                    err_d       = '0;
                    first_d     = '0;
                end
            end
            WR_BURST: begin
                if (!waitrequest) begin
                    if (beat_q == LAST_BEAT) begin
                        wr_ptr_d = next_wr;
                        beat_d   = 8'd0;
                        if (next_wr == END_ADDR) begin
                            state_d   = RD_CMD;
                            write_d   = 1'b0;
                            read_d    = 1'b1;
                            address_d = rd_ptr_q;
                        end else begin
                            address_d   = next_wr;
                            writedata_d = pattern(next_wr);
                        end
                    end else begin
                        beat_d      = beat_q + 8'd1;
                        writedata_d = pattern(wr_beat_addr);
                    end
                end
            end
            RD_CMD: begin
                if (!waitrequest) begin
                    state_d = RD_DATA;
                    read_d  = 1'b0;
                    beat_d  = 8'd0;
                end
            end
            RD_DATA: begin
                if (readdatavalid) begin
                    // errorCount==0 doubles as "no mismatch seen yet"
                    if (readdata != pattern(rd_beat_addr)) begin
                        if (err_q != ERR_MAX) err_d = err_q + 1'b1;
                        if (err_q == '0) first_d = rd_beat_addr;
                    end
                    if (beat_q == LAST_BEAT) begin
                        rd_ptr_d = next_rd;
                        beat_d   = 8'd0;
                        if (next_rd == END_ADDR) begin
                            state_d = DONE;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                            pass_d  = (err_d == '0);
                        end else begin
                            state_d   = RD_CMD;
                            read_d    = 1'b1;
                            address_d = next_rd;
                        end
                    end else begin
                        beat_d = beat_q + 8'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge systemClock) begin
        if (reset) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            beat_q      <= '0;
            address_q   <= '0;
            write_q     <= 1'b0;
            writedata_q <= '0;
            read_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            err_q       <= '0;
            first_q     <= '0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            beat_q      <= beat_d;
            address_q   <= address_d;
            write_q     <= write_d;
            writedata_q <= writedata_d;
            read_q      <= read_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            err_q       <= err_d;
            first_q     <= first_d;
        end
    end

    assign address           = address_q;
    assign burstcount        = 8'(BURST_LEN);
    assign byteenable        = '1;
    assign write             = write_q;
    assign writedata         = writedata_q;
    assign read              = read_q;
    assign busy              = busy_q;
    assign done              = done_q;
    assign pass              = pass_q;
    assign errorCount        = err_q;
    assign firstErrorAddress = first_q;

endmodule

// File: tb/tb_avalon_burst_mem_tester.sv
// Bench for avalon_burst_mem_tester: three parameterisations, a behavioural
// Avalon slave memory and a result scoreboard.
module tb_avalon_burst_mem_tester;

    localparam int            AW   = 29;
    localparam int            DW   = 64;
    localparam int            NI   = 3;
    localparam logic [AW-1:0] BASE = 29'h0700_0000;
    localparam logic [31:0]   SEED = 32'hDEAD_BEEF;
    localparam int            BLV [NI] = '{8, 8, 1};
    localparam int            WCV [NI] = '{1024, 1024, 4};
    localparam int            EWV [NI] = '{16, 4, 16};

    typedef struct {
        int            inst;
        logic [15:0]   ec;
        logic [AW-1:0] fea;
        logic          pass;
    } res_t;

    typedef struct {
        int inst;
        int due;
        int kind;
    } snap_t;

    typedef struct {
        int            due;
        logic [AW-1:0] a;
    } beat_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          m_rst   [NI];
    logic          m_start [NI];
    logic          m_wreq  [NI];
    logic          m_rdv   [NI];
    logic [DW-1:0] m_rdata [NI];
    logic [AW-1:0] m_addr  [NI];
    logic [7:0]    m_bc    [NI];
    logic [7:0]    m_be    [NI];
    logic          m_wr    [NI];
    logic [DW-1:0] m_wdata [NI];
    logic          m_rd    [NI];
    logic          m_busy  [NI];
    logic          m_done  [NI];
    logic          m_pass  [NI];
    logic [15:0]   m_ec    [NI];
    logic [AW-1:0] m_fea   [NI];

    for (genvar g = 0; g < NI; g++) begin : g_dut
        logic [EWV[g]-1:0] ec;
        avalon_burst_mem_tester #(
            .ADDR_WIDTH (AW),
            .DATA_WIDTH (DW),
            .BURST_LEN  (BLV[g]),
            .BASE_ADDR  (BASE),
            .WORD_COUNT (WCV[g]),
            .SEED       (SEED),
            .ERR_WIDTH  (EWV[g])
        ) dut (
            .systemClock       (clk),
            .reset             (m_rst[g]),
            .start             (m_start[g]),
            .address           (m_addr[g]),
            .burstcount        (m_bc[g]),
            .byteenable        (m_be[g]),
            .write             (m_wr[g]),
            .writedata         (m_wdata[g]),
            .read              (m_rd[g]),
            .waitrequest       (m_wreq[g]),
            .readdata          (m_rdata[g]),
            .readdatavalid     (m_rdv[g]),
            .busy              (m_busy[g]),
            .done              (m_done[g]),
            .pass              (m_pass[g]),
            .errorCount        (ec),
            .firstErrorAddress (m_fea[g])
        );
        assign m_ec[g] = 16'(ec);
    end

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int act = 0;
    int wait_pct = 0;
    int lmin = 2;
    int lmax = 2;
    int fmode = 0;
    int tmo_n = 0;
    int tmo_seen = 0;

    res_t  res_q [$];
    snap_t snap_q [$];
    beat_t pend [$];
    logic [DW-1:0] mem [logic [AW-1:0]];

    function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
        logic [31:0] w;
        w = 32'(a) ^ SEED;
        return {w, w};
    endfunction

    function automatic logic faulty(input int fm, input logic [AW-1:0] a);
        if (fm == 2) return 1'b1;
        if (fm == 1) return (a == BASE + AW'(5)) || (a == BASE + AW'(900));
        return 1'b0;
    endfunction

    // Expected outcome of one full run, straight from the fault map
    function automatic res_t model(input int i, input int fm);
        res_t r;
        int n;
        int lim;
        logic found;
        n = 0;
        found = 1'b0;
        r.inst = i;
        r.fea = '0;
        for (int k = 0; k < WCV[i]; k++) begin
            logic [AW-1:0] a;
            a = BASE + AW'(k);
            if (faulty(fm, a)) begin
                if (!found) r.fea = a;
                found = 1'b1;
                n++;
            end
        end
        lim = (1 << EWV[i]) - 1;
        r.ec = 16'((n > lim) ? lim : n);
        r.pass = (n == 0);
        return r;
    endfunction

    function automatic logic [DW-1:0] rd_model(input logic [AW-1:0] a);
        logic [DW-1:0] d;
        d = mem.exists(a) ? mem[a] : '0;
        if (fmode == 2) d = '0;
        if (fmode == 1 && faulty(1, a)) d[0] = ~d[0];
        return d;
    endfunction

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s inst=%0d got=%0h expected=%0h", nm, act, got, exp);
        end
    endtask

    task automatic check_snap(input snap_t s);
        int j;
        j = s.inst;
        chk("snap_busy", 64'(m_busy[j]), 64'(s.kind == 1));
        chk("snap_done", 64'(m_done[j]), 64'd0);
        chk("snap_pass", 64'(m_pass[j]), 64'd0);
        chk("snap_ec", 64'(m_ec[j]), 64'd0);
        chk("snap_write", 64'(m_wr[j]), 64'(s.kind == 1));
        chk("snap_be", 64'(m_be[j]), 64'hFF);
        chk("snap_bc", 64'(m_bc[j]), 64'(BLV[j]));
        if (s.kind == 0) begin
            chk("rst_addr", 64'(m_addr[j]), 64'd0);
            chk("rst_read", 64'(m_rd[j]), 64'd0);
            chk("rst_wdata", 64'(m_wdata[j]), 64'd0);
            chk("rst_fea", 64'(m_fea[j]), 64'd0);
        end
    endtask

    logic          prev_busy = 1'b0;
    logic          prev_done = 1'b0;
    logic          prev_stall = 1'b0;
    logic [AW-1:0] prev_addr = '0;
    logic [DW-1:0] prev_wdata = '0;
    int            wcnt = 0;
    int            rcnt = 0;

    // Slave model and monitor: drives waitrequest/read beats, checks outputs
    always @(negedge clk) begin : mon
        int i;
        int lat;
        logic w;
        beat_t p;
        res_t r;
        snap_t s;
        cyc++;
        for (int k = 0; k < NI; k++) begin
            m_wreq[k] = 1'b0;
            m_rdv[k] = 1'b0;
            m_rdata[k] = '0;
        end
        i = act;
        if (tmo_n != tmo_seen) begin
            tmo_seen = tmo_n;
            chk("done_within_bound", 64'(m_done[i]), 64'd1);
        end
        w = ($urandom_range(99) < wait_pct);
        m_wreq[i] = w;
        if (m_busy[i] && !prev_busy) begin
            wcnt = 0;
            rcnt = 0;
            pend.delete();
            prev_stall = 1'b0;
        end
        if (prev_stall) begin
            chk("stall_write", 64'(m_wr[i]), 64'd1);
            chk("stall_addr", 64'(m_addr[i]), 64'(prev_addr));
            chk("stall_wdata", m_wdata[i], prev_wdata);
            chk("stall_bc", 64'(m_bc[i]), 64'(BLV[i]));
        end
        if (m_wr[i] && !w) begin
            chk("wr_addr", 64'(m_addr[i]), 64'(BASE + AW'((wcnt / BLV[i]) * BLV[i])));
            chk("wr_data", m_wdata[i], pat(BASE + AW'(wcnt)));
            mem[m_addr[i] + AW'(wcnt % BLV[i])] = m_wdata[i];
            wcnt++;
        end
        prev_stall = m_wr[i] && w;
        prev_addr = m_addr[i];
        prev_wdata = m_wdata[i];
        if (m_rd[i] && !w) begin
            chk("rd_addr", 64'(m_addr[i]), 64'(BASE + AW'(rcnt * BLV[i])));
            chk("rd_outstanding", 64'(pend.size()), 64'd0);
            lat = $urandom_range(lmax, lmin);
            for (int k = 0; k < BLV[i]; k++)
                pend.push_back('{due: cyc + lat + k, a: m_addr[i] + AW'(k)});
            rcnt++;
        end
        if (pend.size() > 0 && pend[0].due <= cyc) begin
            p = pend.pop_front();
            m_rdv[i] = 1'b1;
            m_rdata[i] = rd_model(p.a);
        end
        if (m_done[i] && !prev_done) begin
            if (res_q.size() == 0) begin
                chk("unexpected_done", 64'(m_done[i]), 64'd0);
            end else begin
                r = res_q.pop_front();
                chk("errorCount", 64'(m_ec[i]), 64'(r.ec));
                chk("firstErrorAddress", 64'(m_fea[i]), 64'(r.fea));
                chk("pass", 64'(m_pass[i]), 64'(r.pass));
                chk("busy_at_done", 64'(m_busy[i]), 64'd0);
                chk("write_beats", 64'(wcnt), 64'(WCV[i]));
                chk("read_cmds", 64'(rcnt), 64'(WCV[i] / BLV[i]));
            end
        end
        prev_busy = m_busy[i];
        prev_done = m_done[i];
        while (snap_q.size() > 0 && snap_q[0].due <= cyc) begin
            s = snap_q.pop_front();
            check_snap(s);
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic pulse(input int i);
        tick();
        m_start[i] = 1'b1;
        tick();
        m_start[i] = 1'b0;
    endtask

    task automatic run(input int i, input int wp, input int l0, input int l1, input int fm);
        act = i;
        wait_pct = wp;
        lmin = l0;
        lmax = l1;
        fmode = fm;
        res_q.push_back(model(i, fm));
        pulse(i);
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (res_q.size() > 0 && n < 30000) begin
            tick();
            n++;
        end
        if (res_q.size() > 0) begin
            tmo_n++;
            res_q.delete();
        end
        tick();
    endtask

    initial begin
        int n;
        for (int k = 0; k < NI; k++) begin
            m_rst[k] = 1'b1;
            m_start[k] = 1'b0;
        end
        repeat (3) tick();
        for (int k = 0; k < NI; k++) snap_q.push_back('{inst: k, due: cyc + 2, kind: 0});
        tick();
        for (int k = 0; k < NI; k++) m_rst[k] = 1'b0;
        tick();

        run(0, 0, 2, 2, 0);
        wait_done();

        // Reset while the third beat of the second burst is on the bus
        run(0, 0, 2, 2, 0);
        n = 0;
        while (wcnt < BLV[0] + 2 && n < 1000) begin
            tick();
            n++;
        end
        if (wcnt < BLV[0] + 2) tmo_n++;
        m_rst[0] = 1'b1;
        snap_q.push_back('{inst: 0, due: cyc + 2, kind: 0});
        tick();
        m_rst[0] = 1'b0;
        res_q.delete();
        tick();
        run(0, 0, 4, 4, 0);
        wait_done();

        run(0, 50, 3, 10, 0);
        wait_done();

        run(0, 0, 2, 5, 1);
        wait_done();

        run(1, 25, 1, 3, 2);
        wait_done();

        // Starts issued while busy must be ignored
        run(2, 0, 3, 3, 0);
        repeat (2) pulse(2);
        wait_done();
        res_q.push_back(model(2, 0));
        pulse(2);
        snap_q.push_back('{inst: 2, due: cyc + 1, kind: 1});
        wait_done();

        repeat (5) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
